pipe_ctrl: RTL

Pipeline sequencing controller for the 5-stage RISC-V core. It drives the enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers:
- inserts load-use bubbles into ID/EX;
- squashes wrong-path instructions on a taken branch;
- freezes the pipe while data memory is not ready;
- latches a sticky error on a memory-stall timeout.

It also keeps saturating stall and flush counters for debug.

---
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Sequencing controller for the 5-stage core: load-use bubbles, branch squash,
// data-memory freeze with timeout error, plus saturating debug counters.
module pipe_ctrl #(
    parameter int LU_BUBBLES  = 1,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic [6:0]  ex_opcode,
    input  logic        br_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  state,
    output logic        mem_err,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        ERR      = 2'b10
    } state_e;

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    state_e      state_q, state_d;
    logic [1:0]  lu_cnt_q, lu_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    logic hazard;
    logic mem_stall;

    assign hazard = (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign mem_stall = dmem_req && !dmem_ready;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        lu_cnt_d   = lu_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        mem_err_d  = mem_err_q;
        stall_d    = stall_q;
        flush_d    = flush_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        if (state_q == ERR) begin
            tmo_cnt_d = tmo_cnt_q;
        end else if (mem_stall) begin
            // Everything frozen; held pipeline registers re-present any branch/hazard later.
            stall_d   = sat_inc(stall_q);
            tmo_cnt_d = tmo_cnt_q + 8'd1;
            if (tmo_cnt_q == 8'(MEM_TIMEOUT - 1)) begin
                state_d   = ERR;
                mem_err_d = 1'b1;
            end
        end else begin
            tmo_cnt_d = 8'd0;
            if (br_taken) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_d    = RUN;
                lu_cnt_d   = 2'd0;
                flush_d    = sat_inc(flush_q);
            end else if ((state_q == LU_STALL) || hazard) begin
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                stall_d    = sat_inc(stall_q);
                if (state_q == LU_STALL) begin
                    lu_cnt_d = lu_cnt_q - 2'd1;
                    if (lu_cnt_q == 2'd1) begin
                        state_d = RUN;
                    end
                end else if (LU_BUBBLES > 1) begin
                    state_d  = LU_STALL;
                    lu_cnt_d = 2'(LU_BUBBLES - 1);
                end
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
            end
        end

        // Keep the pipe quiet while reset is held, not just after the first edge.
        if (reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            lu_cnt_q  <= 2'd0;
            tmo_cnt_q <= 8'd0;
            mem_err_q <= 1'b0;
            stall_q   <= 16'd0;
            flush_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            lu_cnt_q  <= lu_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            mem_err_q <= mem_err_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign state        = state_q;
    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule
